// File: rtl/hazard_controller.sv
// Front-end sequencing for the 5-stage core: decides per cycle whether IF/ID/EX
// advance, hold (load-use bubble, data-memory freeze) or flush on a mispredict.
module hazard_controller #(
    parameter int COUNT_W      = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid_i,
    input  logic [4:0]         rs1_addr_i,
    input  logic [4:0]         rs2_addr_i,
    input  logic               rs1_used_i,
    input  logic               rs2_used_i,
    input  logic [4:0]         id_rd_i,
    input  logic               id_we_i,
    input  logic               id_is_load_i,
    input  logic               mispredict_i,
    input  logic               mem_busy_i,
    output logic               pc_write_en_o,
    output logic               if_id_write_en_o,
    output logic               buble_o,
    output logic               flush_o,
    output logic               freeze_o,
    output logic [COUNT_W-1:0] stall_cycles_o,
    output logic [COUNT_W-1:0] flush_events_o
);

    // state  | meaning
    // RUN    | normal issue; services mispredicts and load-use bubbles
    // FLUSH  | extra flush cycles after a mispredict, flush_cnt still owed
    // FREEZE | data memory busy; a saved flush_cnt resumes FLUSH afterwards
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_FREEZE} state_t;

    localparam logic [2:0]         FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE    = COUNT_W'(1);

    state_t     state;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       mis_pending;
    logic [2:0] flush_cnt;

    logic flush_active;
    logic redirect;
    logic load_use;

    // A non-zero count is only ever left behind by a mispredict, so it alone
    // marks an unfinished flush, whether we are flushing or frozen mid-flush.
    assign flush_active = (state != ST_RUN) && (flush_cnt != 3'd0);

    assign load_use = ex_valid && ex_load && (ex_rd != 5'd0) &&
                      ((rs1_used_i && (rs1_addr_i == ex_rd)) ||
                       (rs2_used_i && (rs2_addr_i == ex_rd)));

    always_comb begin
        pc_write_en_o    = 1'b1;
        if_id_write_en_o = 1'b1;
        buble_o          = 1'b0;
        flush_o          = 1'b0;
        freeze_o         = 1'b0;
        redirect         = 1'b0;
        if (!reset) begin
            redirect = 1'b0;
        end else if (mem_busy_i) begin
            freeze_o         = 1'b1;
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
        end else if (flush_active) begin
            flush_o = 1'b1;
        end else if (mispredict_i || mis_pending) begin
            flush_o  = 1'b1;
            redirect = 1'b1;
        end else if (load_use) begin
            buble_o          = 1'b1;
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_RUN;
            ex_valid       <= 1'b0;
            ex_rd          <= 5'd0;
            ex_load        <= 1'b0;
            mis_pending    <= 1'b0;
            flush_cnt      <= 3'd0;
            stall_cycles_o <= '0;
            flush_events_o <= '0;
        end else begin
            if ((buble_o || freeze_o) && (stall_cycles_o != COUNT_MAX))
                stall_cycles_o <= stall_cycles_o + COUNT_ONE;
            if (redirect && (flush_events_o != COUNT_MAX))
                flush_events_o <= flush_events_o + COUNT_ONE;

            if (mem_busy_i) begin
                state <= ST_FREEZE;
                // During an unfinished flush EX only holds killed bubbles
                if (mispredict_i && !flush_active)
                    mis_pending <= 1'b1;
            end else if (flush_active) begin
                ex_valid  <= 1'b0;
                flush_cnt <= flush_cnt - 3'd1;
                state     <= (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
            end else if (redirect) begin
                ex_valid    <= 1'b0;
                mis_pending <= 1'b0;
                flush_cnt   <= FLUSH_RELOAD;
                state       <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            end else if (load_use) begin
                ex_valid <= 1'b0;
                state    <= ST_RUN;
            end else begin
                ex_valid <= id_valid_i && id_we_i;
                ex_rd    <= id_rd_i;
                ex_load  <= id_is_load_i;
                state    <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (FLUSH_CYCLES=2/COUNT_W=16 and
// FLUSH_CYCLES=4/COUNT_W=4) share stimulus and are checked against a cycle model.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, rs1_used, rs2_used, id_we, id_load, mispredict, mem_busy;
    logic [4:0] rs1_addr, rs2_addr, id_rd;

    logic pc_a, ifid_a, bub_a, fl_a, fz_a;
    logic pc_b, ifid_b, bub_b, fl_b, fz_b;
    logic [15:0] stall_a, fev_a;
    logic [3:0]  stall_b, fev_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(.COUNT_W(16), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .id_valid_i(id_valid),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_load),
        .mispredict_i(mispredict), .mem_busy_i(mem_busy),
        .pc_write_en_o(pc_a), .if_id_write_en_o(ifid_a), .buble_o(bub_a),
        .flush_o(fl_a), .freeze_o(fz_a),
        .stall_cycles_o(stall_a), .flush_events_o(fev_a)
    );

    hazard_controller #(.COUNT_W(4), .FLUSH_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .id_valid_i(id_valid),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_load),
        .mispredict_i(mispredict), .mem_busy_i(mem_busy),
        .pc_write_en_o(pc_b), .if_id_write_en_o(ifid_b), .buble_o(bub_b),
        .flush_o(fl_b), .freeze_o(fz_b),
        .stall_cycles_o(stall_b), .flush_events_o(fev_b)
    );

    // Reference model: owed flush cycles, pending redirect, EX occupant, counters
    int m_left[2], m_stall[2], m_flushes[2], m_exrd[2];
    bit m_pend[2], m_exv[2], m_exl[2];
    int fc[2]   = '{2, 4};
    int cmax[2] = '{65535, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_stall[i] = 0; m_flushes[i] = 0; m_exrd[i] = 0;
            m_pend[i] = 0; m_exv[i] = 0; m_exl[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        logic [4:0]  obs, exp;
        logic [31:0] obs_st, obs_fe;
        bit pc, ifid, bub, fl, fz, hazard;
        pc = 1; ifid = 1; bub = 0; fl = 0; fz = 0;
        hazard = m_exv[i] && m_exl[i] && m_exrd[i] != 0 &&
                 ((rs1_used && int'(rs1_addr) == m_exrd[i]) ||
                  (rs2_used && int'(rs2_addr) == m_exrd[i]));
        obs    = (i == 0) ? {pc_a, ifid_a, bub_a, fl_a, fz_a} : {pc_b, ifid_b, bub_b, fl_b, fz_b};
        obs_st = (i == 0) ? 32'(stall_a) : 32'(stall_b);
        obs_fe = (i == 0) ? 32'(fev_a) : 32'(fev_b);
        check($sformatf("stall_cnt%0d", i), obs_st, m_stall[i]);
        check($sformatf("flush_cnt%0d", i), obs_fe, m_flushes[i]);
        if (mem_busy) begin
            fz = 1; pc = 0; ifid = 0;
            if (mispredict && m_left[i] == 0) m_pend[i] = 1;
        end else if (m_left[i] > 0) begin
            fl = 1; m_exv[i] = 0; m_left[i]--;
        end else if (mispredict || m_pend[i]) begin
            fl = 1; m_pend[i] = 0; m_exv[i] = 0; m_left[i] = fc[i] - 1;
            if (m_flushes[i] < cmax[i]) m_flushes[i]++;
        end else if (hazard) begin
            bub = 1; pc = 0; ifid = 0; m_exv[i] = 0;
        end else begin
            m_exv[i] = id_valid && id_we; m_exrd[i] = int'(id_rd); m_exl[i] = id_load;
        end
        if ((bub || fz) && m_stall[i] < cmax[i]) m_stall[i]++;
        exp = {pc, ifid, bub, fl, fz};
        check($sformatf("outputs%0d", i), 32'(obs), 32'(exp));
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        id_rd = 0; id_we = 0; id_load = 0; mispredict = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        #1;
        check("rst_out_a", 32'({pc_a, ifid_a, bub_a, fl_a, fz_a}), 32'b11000);
        check("rst_out_b", 32'({pc_b, ifid_b, bub_b, fl_b, fz_b}), 32'b11000);
        check("rst_cnt_a", 32'({stall_a, fev_a}), 0);
        check("rst_cnt_b", 32'({stall_b, fev_b}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check("post_rst_out_b", 32'({pc_b, ifid_b, bub_b, fl_b, fz_b}), 32'b11000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // load-use on x5: exactly one bubble
        id_valid = 1; id_rd = 5; id_we = 1; id_load = 1;
        cycle();
        id_rd = 9; id_we = 0; id_load = 0; rs1_addr = 5; rs1_used = 1;
        #1;
        check("lu_bubble", 32'({bub_a, pc_a, ifid_a}), 32'b100);
        cycle();
        check("lu_resume", 32'({bub_a, pc_a, ifid_a}), 32'b011);
        check("lu_stall_cnt", 32'(stall_a), 1);
        cycle();

        // load into x0 never stalls
        set_idle();
        id_valid = 1; id_rd = 0; id_we = 1; id_load = 1;
        cycle();
        id_load = 0; id_we = 0; rs1_addr = 0; rs1_used = 1; rs2_used = 1;
        #1;
        check("x0_no_bubble", 32'(bub_a), 0);
        cycle();

        // mispredict: load x7 ahead, then a two-cycle flush on dut_a
        set_idle();
        id_valid = 1; id_rd = 7; id_we = 1; id_load = 1;
        cycle();
        id_load = 0; id_we = 0; rs1_addr = 7; rs1_used = 1; mispredict = 1;
        #1;
        check("mis_flush1", 32'({fl_a, bub_a}), 32'b10);
        cycle();
        mispredict = 0;
        #1;
        check("mis_flush2", 32'(fl_a), 1);
        cycle();
        check("mis_flush_done", 32'({fl_a, bub_a}), 32'b00);
        check("mis_events", 32'(fev_a), 1);
        repeat (3) cycle();

        // memory wait with a mispredict in the middle
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mem_busy = 1; mispredict = (k == 1);
            #1;
            check("mw_freeze", 32'({fz_a, fl_a}), 32'b10);
            cycle();
        end
        mem_busy = 0; mispredict = 0;
        #1;
        check("mw_flush_after", 32'({fz_a, fl_a}), 32'b01);
        cycle();
        check("mw_stall_cnt", 32'(stall_a), 3);
        repeat (4) cycle();

        // reset during the second flush cycle of dut_b
        do_reset();
        mispredict = 1;
        cycle();
        mispredict = 0;
        #1;
        check("rmf_flushing", 32'(fl_b), 1);
        do_reset();
        cycle();

        // saturation of the 4-bit counter
        do_reset();
        mem_busy = 1;
        repeat (20) cycle();
        check("sat_stall_b", 32'(stall_b), 15);
        check("sat_stall_a", 32'(stall_a), 20);
        mem_busy = 0;
        cycle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            id_valid   = ($urandom_range(0, 3) != 0);
            rs1_addr   = 5'($urandom_range(0, 3));
            rs2_addr   = 5'($urandom_range(0, 3));
            rs1_used   = $urandom_range(0, 1) != 0;
            rs2_used   = $urandom_range(0, 1) != 0;
            id_rd      = 5'($urandom_range(0, 3));
            id_we      = $urandom_range(0, 3) != 0;
            id_load    = $urandom_range(0, 1) != 0;
            mispredict = ($urandom_range(0, 11) == 0);
            mem_busy   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage RV32I core. It decides each cycle whether the IF/ID/EX front end advances, holds, or is flushed. It drives the `buble` and `flush` inputs of the decode stage and the PC / IF-ID write enables. It tracks the instruction occupying EX (rd, load flag), resolves load-use hazards, branch mispredicts and data-memory wait states, and keeps saturating performance counters.

## Interface
Parameters:
- COUNT_W, 16, width of the stall and flush performance counters.
- FLUSH_CYCLES, 1, number of consecutive cycles `flush_o` is held per mispredict. Legal range 1..7.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- id_valid_i, input, 1, the ID stage holds a real instruction.
- rs1_addr_i, input, 5, source register 1 of the ID instruction.
- rs2_addr_i, input, 5, source register 2 of the ID instruction.
- rs1_used_i, input, 1, the ID instruction reads rs1.
- rs2_used_i, input, 1, the ID instruction reads rs2.
- id_rd_i, input, 5, destination register of the ID instruction.
- id_we_i, input, 1, the ID instruction writes rd.
- id_is_load_i, input, 1, the ID instruction is a load.
- mispredict_i, input, 1, EX resolved a mispredicted branch/jump in this cycle.
- mem_busy_i, input, 1, data memory not ready; the pipeline must freeze.
- pc_write_en_o, output, 1, the PC may update.
- if_id_write_en_o, output, 1, the IF/ID register may load.
- buble_o, output, 1, insert a bubble into ID/EX (decode stage `buble`).
- flush_o, output, 1, kill the IF/ID and ID/EX contents (decode stage `flush`).
- freeze_o, output, 1, hold all pipeline registers from EX onward.
- stall_cycles_o, output, COUNT_W, saturating count of bubble or freeze cycles.
- flush_events_o, output, COUNT_W, saturating count of serviced mispredicts.

## Operation
- State machine states: RUN, FLUSH, FREEZE. Reset state is RUN.
- EX tracker registers: ex_valid, ex_rd[4:0], ex_load. All are cleared on reset.
- Priority within a cycle, highest first: mem_busy_i, then mispredict (fresh or pending), then load-use.
- **RUN**
  - If mem_busy_i=1:
    - freeze_o=1; both enables=0; buble_o=0; flush_o=0.
    - The tracker holds.
    - A mispredict_i in the same cycle sets mis_pending=1.
    - Next state is FREEZE.
  - Else, if mispredict_i or mis_pending is set:
    - flush_o=1; pc_write_en_o=1 (redirect); if_id_write_en_o=1.
    - ex_valid clears; mis_pending clears; flush_events increments.
    - Next state is FLUSH if FLUSH_CYCLES>1, otherwise RUN.
  - Else, if a load-use hazard exists:
    - Condition: ex_valid & ex_load & ex_rd≠0 & ((rs1_used_i & rs1_addr_i==ex_rd) | (rs2_used_i & rs2_addr_i==ex_rd)).
    - buble_o=1; both enables=0; ex_valid clears.
  - Else (normal advance):
    - Both enables=1.
    - The tracker loads ex_valid = id_valid_i & id_we_i, ex_rd = id_rd_i, ex_load = id_is_load_i.
- **FLUSH**
  - flush_o=1 and both enables=1, for FLUSH_CYCLES−1 further cycles, counted by a 3-bit down-counter.
  - ex_valid stays 0.
  - mem_busy_i in FLUSH moves to FREEZE with the remaining count preserved. The flush resumes after the freeze ends.
  - A new mispredict_i in FLUSH is ignored: the younger instruction is already being killed.
- **FREEZE**
  - Outputs are the same as the mem_busy case in RUN.
  - A mispredict_i in FREEZE sets mis_pending.
  - When mem_busy_i falls:
    - Return to FLUSH if a remaining flush count is saved.
    - Otherwise return to RUN, where any pending mispredict is serviced in that first cycle.
- Counters
  - stall_cycles increments in every cycle with buble_o=1 or freeze_o=1.
  - flush_events increments once per serviced mispredict.
  - Both saturate at 2^COUNT_W−1 and never wrap.

## Timing
- pc_write_en_o, if_id_write_en_o, buble_o, flush_o and freeze_o are combinational from the current state, the tracker registers and the inputs of the same cycle. The decode stage samples them at the same rising edge.
- The tracker, state, mis_pending, flush counter and performance counters update on the rising edge.
- Load-use costs exactly 1 bubble cycle. On the next cycle the tracker holds ex_valid=0, so the stalled instruction advances.
- A mispredict asserts flush_o in the same cycle, with no latency.
- While reset is low, and in the first cycle after release:
  - Outputs: pc_write_en_o=1, if_id_write_en_o=1, buble_o=0, flush_o=0, freeze_o=0.
  - Counters read 0.
- Asserting reset in any state returns immediately to RUN. The tracker, mis_pending, the flush counter and both counters clear asynchronously.
- rd=x0 never creates a hazard.

## Test plan
- Load-use:
  - Stimulus: cycle 0 accepts lw with rd=5 (id_is_load_i=1, id_we_i=1). Cycle 1 ID has rs1_addr_i=5 with rs1_used_i=1.
  - Required: cycle 1 buble_o=1, pc_write_en_o=0, if_id_write_en_o=0. Cycle 2 all enables=1, buble_o=0. stall_cycles_o=1.
- Load into x0:
  - Stimulus: lw with rd=0, followed by an instruction reading x0.
  - Required: buble_o never asserts.
- Mispredict with FLUSH_CYCLES=2:
  - Stimulus: pulse mispredict_i for 1 cycle.
  - Required: flush_o=1 for exactly 2 cycles. flush_events_o=1. The next load-use check sees ex_valid=0.
- Memory wait:
  - Stimulus: mem_busy_i=1 for 3 cycles; mispredict_i pulses in the 2nd of those cycles.
  - Required: freeze_o=1 for 3 cycles with flush_o=0. flush_o=1 in the cycle after mem_busy_i falls. stall_cycles_o=3.
- Reset mid-FLUSH:
  - Stimulus: FLUSH_CYCLES=4; assert reset in the 2nd flush cycle.
  - Required: flush_o=0 immediately, counters 0, RUN after release.
- Saturation:
  - Stimulus: COUNT_W=4, hold mem_busy_i for 20 cycles.
  - Required: stall_cycles_o stops at 15.
